// File: rtl/ib_div_16x8_s0_l16.sv
// Sequential unsigned divider, 16-bit dividend by 8-bit divisor.
// Radix-2 restoring, one quotient bit per cycle, MSB first, 16 iterations.
module ib_div_16x8_s0_l16 (
   input  logic        i_clk,
   input  logic        i_nrst,
   input  logic        i_start,
   input  logic [15:0] i_n,
   input  logic [7:0]  i_d,
   output logic [15:0] o_q,
   output logic [7:0]  o_r,
   output logic        o_dz,
   output logic        o_busy,
   output logic        o_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] n_sr_q, n_sr_d;
   logic [7:0]  d_reg_q, d_reg_d;
   logic [8:0]  r9_q, r9_d;
   logic [15:0] q_sr_q, q_sr_d;
   logic [15:0] q_q, q_d;
   logic [7:0]  r_q, r_d;
   logic        dz_q, dz_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [8:0]  t;
   logic        qbit;
   logic [8:0]  r_next;
   logic [15:0] q_next;
   logic        dz_now;

   // One restoring step: trial-subtract divisor from shifted partial remainder
   always_comb begin
      t      = {r9_q[7:0], n_sr_q[15]};
      qbit   = (t >= {1'b0, d_reg_q});
      r_next = qbit ? (t - {1'b0, d_reg_q}) : t;
      q_next = {q_sr_q[14:0], qbit};
      dz_now = (d_reg_q == 8'd0);
   end

   // Next-state: start (always wins, also aborts), iterate, publish result
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      n_sr_d  = n_sr_q;
      d_reg_d = d_reg_q;
      r9_d    = r9_q;
      q_sr_d  = q_sr_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (i_start) begin
         state_d = RUN;
         cnt_d   = 4'd0;
         n_sr_d  = i_n;
         d_reg_d = i_d;
         r9_d    = 9'h0;
         q_sr_d  = 16'h0;
         busy_d  = 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               n_sr_d = {n_sr_q[14:0], 1'b0};
               r9_d   = r_next;
               q_sr_d = q_next;
               cnt_d  = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_d = FIN;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  dz_d    = dz_now;
                  q_d     = dz_now ? 16'hFFFF : q_next;
                  r_d     = r_next[7:0];
               end
            end
            FIN:     state_d = IDLE;
            IDLE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // State and registered outputs
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         n_sr_q  <= 16'h0;
         d_reg_q <= 8'h0;
         r9_q    <= 9'h0;
         q_sr_q  <= 16'h0;
         q_q     <= 16'h0;
         r_q     <= 8'h0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         n_sr_q  <= n_sr_d;
         d_reg_q <= d_reg_d;
         r9_q    <= r9_d;
         q_sr_q  <= q_sr_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign o_q    = q_q;
   assign o_r    = r_q;
   assign o_dz   = dz_q;
   assign o_busy = busy_q;
   assign o_done = done_q;

endmodule
